// File: rtl/bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq
//
// Sequential double-dabble converter. It accepts one unsigned binary operand
// on a start pulse and converts one bit per clock. It then presents the packed
// BCD digits to the 7-segment display driver.
//
// Parameters
//   IN_W    width of the binary operand (default 14)
//   DIGITS  number of BCD digits produced; 10**DIGITS must exceed 2**IN_W-1
//
// Ports
//   clk      in   rising-edge system clock
//   rst      in   asynchronous, active-high reset
//   start    in   conversion request, only looked at while idle
//   bin_in   in   [IN_W-1:0]      binary operand, captured on an accepted start
//   busy     out  high while the shift phase is running
//   done     out  one-cycle pulse, coincident with bcd_out taking a new value
//   bcd_out  out  [4*DIGITS-1:0]  packed BCD, digit 0 in bits [3:0]
//   blank    out  [DIGITS-1:0]    leading-zero blanking mask (optional)
//
// Build option
//   BCD_LZ_BLANK_EN  when defined, adds the blank output. blank[i] is set when
//                    digit i and every digit above it are zero, for i >= 1.
//                    blank[0] is never set, so a value of zero still shows a
//                    single "0". The mask is updated together with bcd_out.
//
// Timing
//   start is sampled at edge N. The shift phase runs on edges N+1..N+IN_W.
//   The result is registered at edge N+IN_W+1, and done is high for the
//   cycle that follows that edge. A new start is accepted at edge N+IN_W+2
//   at the earliest. A start during the shift or done phase is dropped.
// -----------------------------------------------------------------------------
module bin_to_bcd_seq #(
   parameter int IN_W   = 14,
   parameter int DIGITS = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [IN_W-1:0]       bin_in,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd_out
`ifdef BCD_LZ_BLANK_EN
   ,
   output logic [DIGITS-1:0]     blank
`endif
);

   localparam int BCD_W  = 4 * DIGITS;
   localparam int WORK_W = BCD_W + IN_W;
   localparam int CNT_W  = $clog2(IN_W + 1);

   // Count value seen on the last shift cycle.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_W - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // ---------------------------------------------------------------------------
   // State and registered outputs
   // ---------------------------------------------------------------------------
   state_t              state_q,   state_d;
   logic [WORK_W-1:0]   work_q,    work_d;     // {bcd field, binary field}
   logic [CNT_W-1:0]    cnt_q,     cnt_d;
   logic                busy_q,    busy_d;
   logic                done_q,    done_d;
   logic [BCD_W-1:0]    bcd_out_q, bcd_out_d;
`ifdef BCD_LZ_BLANK_EN
   logic [DIGITS-1:0]   blank_q,   blank_d;
   logic [DIGITS-1:0]   blank_calc;
`endif

   // ---------------------------------------------------------------------------
   // One double-dabble step: correct each digit, then shift the register.
   // ---------------------------------------------------------------------------
   logic [BCD_W-1:0]    bcd_field;
   logic [BCD_W-1:0]    bcd_adj;
   logic [WORK_W-1:0]   work_shifted;

   assign bcd_field = work_q[WORK_W-1:IN_W];

   always_comb begin
      // NOTE: every variable assigned in always_comb gets a default value first, so
      // no path can leave it unassigned and infer a latch.
      bcd_adj = bcd_field;
      for (int i = 0; i < DIGITS; i++) begin
         // After a shift, a digit of 5 or more would reach 10 or more. Adding 3
         // first makes the shift carry into the next digit instead. The add
         // stays inside the 4-bit field.
         if (bcd_field[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd_field[4*i +: 4] + 4'd3;
         end
      end
      work_shifted = {bcd_adj, work_q[IN_W-1:0]} << 1;
   end

`ifdef BCD_LZ_BLANK_EN
   // ---------------------------------------------------------------------------
   // Leading-zero mask, computed from the finished BCD field. Scan from the
   // top digit down. A digit is blank only while everything above it has
   // also been zero.
   // ---------------------------------------------------------------------------
   always_comb begin
      logic higher_zero;
      higher_zero = 1'b1;
      blank_calc  = '0;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         higher_zero   = higher_zero & (bcd_field[4*i +: 4] == 4'd0);
         blank_calc[i] = higher_zero;
      end
   end
`endif

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      work_d    = work_q;
      cnt_d     = cnt_q;
      done_d    = 1'b0;
      bcd_out_d = bcd_out_q;
`ifdef BCD_LZ_BLANK_EN
      blank_d   = blank_q;
`endif

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               // The operand goes into the low bits and the BCD field starts
               // at zero. The copy isolates the conversion from later
               // changes on bin_in.
               work_d  = {{BCD_W{1'b0}}, bin_in};
               cnt_d   = '0;
               state_d = ST_SHIFT;
            end
         end

         ST_SHIFT: begin
            work_d = work_shifted;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = ST_DONE;
            end
         end

         ST_DONE: begin
            // Only completed results reach the outputs. The display never
            // shows a partially shifted value.
            bcd_out_d = bcd_field;
`ifdef BCD_LZ_BLANK_EN
            blank_d   = blank_calc;
`endif
            done_d    = 1'b1;
            state_d   = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // busy is registered. It follows the state being entered, so it rises
      // on the edge that accepts start and falls on the edge leaving SHIFT.
      busy_d = (state_d == ST_SHIFT);
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // The working register and counter are plain flops, not a memory.
         // Clearing them keeps an aborted conversion from leaving stale bits.
         state_q   <= ST_IDLE;
         work_q    <= '0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         bcd_out_q <= '0;
`ifdef BCD_LZ_BLANK_EN
         blank_q   <= {{(DIGITS-1){1'b1}}, 1'b0};
`endif
      end else begin
         // NOTE: sequential state uses non-blocking assignments so that every
         // flop samples the pre-edge values, whatever the statement order.
         state_q   <= state_d;
         work_q    <= work_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         bcd_out_q <= bcd_out_d;
`ifdef BCD_LZ_BLANK_EN
         blank_q   <= blank_d;
`endif
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign bcd_out = bcd_out_q;
`ifdef BCD_LZ_BLANK_EN
   assign blank   = blank_q;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_bin_to_bcd_seq
//
// Self-checking bench for bin_to_bcd_seq.
//
// The stimulus process issues start requests. For every request the
// converter should accept, it pushes the operand and the acceptance edge into
// a queue. A separate monitor process samples the DUT on the falling edge. It
// takes each request from the queue when its acceptance edge arrives. From
// the operand and that edge it works out what busy, done, bcd_out (and blank)
// must show each cycle. Expected digits come from decimal arithmetic on the
// operand.
// -----------------------------------------------------------------------------
module tb_bin_to_bcd_seq;

   localparam int IN_W   = 14;
   localparam int DIGITS = 5;
   localparam int BCD_W  = 4 * DIGITS;
   localparam int MAX_V  = (1 << IN_W) - 1;

   logic               clk;
   logic               rst;
   logic               start;
   logic [IN_W-1:0]    bin_in;
   logic               busy;
   logic               done;
   logic [BCD_W-1:0]   bcd_out;
`ifdef BCD_LZ_BLANK_EN
   logic [DIGITS-1:0]  blank;
`endif

   bin_to_bcd_seq #(
      .IN_W   (IN_W),
      .DIGITS (DIGITS)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .bin_in  (bin_in),
      .busy    (busy),
      .done    (done),
      .bcd_out (bcd_out)
`ifdef BCD_LZ_BLANK_EN
      ,
      .blank   (blank)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Rising-edge count. After edge k has happened, cyc reads k.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vectors    = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s at edge %0d: got %h, expected %h", name, cyc, got, exp);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model: decimal digits and leading-zero mask by plain arithmetic
   // ---------------------------------------------------------------------------
   function automatic logic [BCD_W-1:0] ref_bcd(input int unsigned v);
      logic [BCD_W-1:0] r;
      int unsigned      rest;
      r    = '0;
      rest = v;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(rest % 10);
         rest        = rest / 10;
      end
      return r;
   endfunction

   // Digit i and all higher digits are zero exactly when v < 10**i.
   function automatic logic [DIGITS-1:0] ref_blank(input int unsigned v);
      logic [DIGITS-1:0] b;
      int unsigned       p;
      b = '0;
      p = 1;
      for (int i = 1; i < DIGITS; i++) begin
         p    = p * 10;
         b[i] = (v < p);
      end
      return b;
   endfunction

   localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

   // ---------------------------------------------------------------------------
   // Scoreboard queue: requests the converter should accept
   // ---------------------------------------------------------------------------
   typedef struct {
      int unsigned val;
      int          start_cyc;   // rising edge that samples the start
   } req_t;

   req_t exp_q[$];
   int   next_ok = 0;           // earliest edge at which a start is accepted

   // ---------------------------------------------------------------------------
   // Monitor
   // ---------------------------------------------------------------------------
   initial begin
      req_t              cur;
      bit                inflight;
      logic [BCD_W-1:0]  mdl_bcd;
      logic [DIGITS-1:0] mdl_blank;
      logic              busy_exp;
      logic              done_exp;
      inflight  = 1'b0;
      mdl_bcd   = '0;
      mdl_blank = BLANK_RST;
      cur       = '{val: 0, start_cyc: 0};
      forever begin
         @(negedge clk);
         if (rst) begin
            inflight  = 1'b0;
            mdl_bcd   = '0;
            mdl_blank = BLANK_RST;
         end else if (!inflight && exp_q.size() > 0 && exp_q[0].start_cyc == cyc) begin
            cur      = exp_q.pop_front();
            inflight = 1'b1;
         end
         busy_exp = inflight && (cyc <= cur.start_cyc + IN_W - 1);
         done_exp = inflight && (cyc == cur.start_cyc + IN_W + 1);
         if (done_exp) begin
            mdl_bcd   = ref_bcd(cur.val);
            mdl_blank = ref_blank(cur.val);
            inflight  = 1'b0;
         end
         check("busy", 32'(busy), 32'(busy_exp));
         check("done", 32'(done), 32'(done_exp));
         check("bcd_out", 32'(bcd_out), 32'(mdl_bcd));
`ifdef BCD_LZ_BLANK_EN
         check("blank", 32'(blank), 32'(mdl_blank));
`endif
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers. Inputs change 2 time units after a rising edge.
   // ---------------------------------------------------------------------------
   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Hold start for one cycle. The edge that samples it is cyc+1. It is
   // accepted only if the converter is back in IDLE by then.
   task automatic issue(input int unsigned v);
      req_t r;
      start  = 1'b1;
      bin_in = IN_W'(v);
      if (!rst && (cyc + 1 >= next_ok)) begin
         r.val       = v;
         r.start_cyc = cyc + 1;
         exp_q.push_back(r);
         next_ok = cyc + 1 + IN_W + 2;
      end
      step();
      start = 1'b0;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      exp_q.delete();
      next_ok = 0;
      step(2);
      rst = 1'b0;
      step();
   endtask

   // ---------------------------------------------------------------------------
   // Sequence
   // ---------------------------------------------------------------------------
   initial begin
      rst    = 1'b1;
      start  = 1'b0;
      bin_in = '0;
      step(3);
      rst = 1'b0;
      step(2);

      // Zero operand, then full scale.
      issue(0);      step(16);
      issue(MAX_V);  step(16);

      // Operand changes right after capture.
      issue(1234);
      bin_in = IN_W'(9999);
      step(16);

      // Starts during SHIFT and during DONE are both dropped.
      issue(63);
      step(3);
      issue(500);    // sampled mid-SHIFT
      step(10);
      issue(777);    // sampled on the DONE edge
      step(16);

      // Reset partway through a conversion, then convert again.
      issue(4095);   step(16);
      issue(100);    step(6);
      pulse_reset();
      step(2);
      issue(100);    step(16);

      // Back-to-back: second start at the earliest edge it is allowed.
      issue(9);      step(15);
      issue(10);     step(16);

      // Random operands and random start timing.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 7))
               0:       issue(0);
               1:       issue(MAX_V);
               default: issue($urandom_range(0, MAX_V));
            endcase
         end else begin
            step();
         end
      end
      start = 1'b0;
      step(20);

      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL pending: %0d accepted requests never produced done", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
